// File: rtl/std_cache_bypass_arbiter.sv
// ---------------------------------------------------------------------------
// std_cache_bypass_arbiter
//
// Round-robin arbiter that funnels NR_PORTS uncached/bypass requesters onto
// the single bypass port of the miss handler. Only one transaction is in
// flight at a time. The response is steered back to the port that issued it.
//
// Optional feature: define STD_CACHE_BYPASS_TIMEOUT_EN to add a WAIT-state
// watchdog. After TIMEOUT_CYCLES cycles in WAIT with no response, the
// watchdog completes the transaction with a poison data word and pulses
// err_o for one cycle.
//
// The request and response records are packed onto flat ports. The field
// layout is defined by the bypass_req_t / bypass_rsp_t typedefs below, with
// the first-listed field at the MSB end.
// ---------------------------------------------------------------------------
module std_cache_bypass_arbiter #(
    parameter int NR_PORTS       = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int REQ_W         = 148,
    localparam int RSP_W         = 66,
    localparam int IDX_W         = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NR_PORTS*REQ_W-1:0] req_i,
    output logic [NR_PORTS*RSP_W-1:0] rsp_o,
    output logic [REQ_W-1:0]          bus_req_o,
    input  logic [RSP_W-1:0]          bus_rsp_i,
    output logic                      busy_o,
    output logic                      err_o
);

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  amo_op;
        logic [1:0]  size;
        logic [7:0]  be;
        logic [3:0]  id;
        logic [63:0] addr;
        logic [63:0] wdata;
    } bypass_req_t;

    typedef struct packed {
        logic        gnt;
        logic        valid;
        logic [63:0] rdata;
    } bypass_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [63:0] TIMEOUT_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

    // Elaboration-time sanity check on the configuration.
    if (NR_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("std_cache_bypass_arbiter: NR_PORTS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_e              state_q;
    logic [IDX_W-1:0]    rr_q;
    logic [IDX_W-1:0]    idx_q;
    bypass_req_t         req_q;

    bypass_req_t         req_arr [NR_PORTS];
    bypass_rsp_t         bus_rsp;
    bypass_req_t         bus_req;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_sel;
    logic                gnt_en;
    logic                fwd_valid;
    logic [63:0]         fwd_rdata;
    logic                timeout_hit;

    assign bus_rsp = bypass_rsp_t'(bus_rsp_i);

    // Unpack the flat upstream request bus into per-port records.
    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            req_arr[p] = bypass_req_t'(req_i[p*REQ_W +: REQ_W]);
        end
    end

    // Round-robin pick: first requesting port at or after rr_q, wrapping around.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        int cand;
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = 0;
        for (int k = 0; k < NR_PORTS; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NR_PORTS) begin
                cand = cand - NR_PORTS;
            end
            if (!arb_found && req_arr[cand].req) begin
                arb_found = 1'b1;
                arb_sel   = IDX_W'(cand);
            end
        end
    end

    // The grant is combinational and only issued from IDLE. It is suppressed
    // while reset is held so that every response field reads zero during reset.
    assign gnt_en = (state_q == IDLE) && arb_found && !rst_i;

`ifdef STD_CACHE_BYPASS_TIMEOUT_EN
    logic [31:0] wait_cnt_q;

    // Watchdog counter: cleared on the REQ->WAIT transition and advanced on every WAIT cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == REQ && bus_rsp.gnt) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle if the real response has not arrived.
    assign timeout_hit = (state_q == WAIT) && !bus_rsp.valid
                       && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign err_o = timeout_hit;

    // Decide whether a response goes upstream this cycle, and which data it carries.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rdata = '0;
        case (state_q)
            REQ: begin
                if (bus_rsp.gnt && bus_rsp.valid) begin
                    fwd_valid = 1'b1;
                    fwd_rdata = bus_rsp.rdata;
                end
            end
            WAIT: begin
                if (bus_rsp.valid) begin
                    fwd_valid = 1'b1;
                    fwd_rdata = bus_rsp.rdata;
                end else if (timeout_hit) begin
                    fwd_valid = 1'b1;
                    fwd_rdata = TIMEOUT_RDATA;
                end
            end
            default: begin
                fwd_valid = 1'b0;
                fwd_rdata = '0;
            end
        endcase
    end

    // Route the grant to the selected port and the response to the latched port. All other ports see zeros.
    always_comb begin
        bypass_rsp_t r;
        rsp_o = '0;
        r     = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            r       = '0;
            r.gnt   = gnt_en && (arb_sel == IDX_W'(p));
            r.valid = fwd_valid && (idx_q == IDX_W'(p));
            r.rdata = r.valid ? fwd_rdata : 64'd0;
            rsp_o[p*RSP_W +: RSP_W] = r;
        end
    end

    // The downstream request is driven only in REQ. It comes straight from the latched copy, so it stays stable until granted.
    always_comb begin
        bus_req = '0;
        if (state_q == REQ) begin
            bus_req     = req_q;
            bus_req.req = 1'b1;
        end
    end

    assign bus_req_o = bus_req;
    assign busy_o    = (state_q != IDLE);

    // Transaction FSM: IDLE grants and latches, REQ presents downstream, WAIT collects the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            req_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        req_q   <= req_arr[arb_sel];
                        idx_q   <= arb_sel;
                        rr_q    <= (arb_sel == IDX_W'(NR_PORTS - 1)) ? '0 : arb_sel + IDX_W'(1);
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus_rsp.gnt) begin
                        state_q <= bus_rsp.valid ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rsp.valid || timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
